int_request_arb: RTL and testbench

// - Downstream consumer of the 13 interrupt control register (ICR) inhibit latches.
// - Edge-detects 13 discrete interrupt sources and holds each as a pending bit.
// - Masks pending bits with the ICR inhibits and raises INTREQ to the LVDC.
// - Hands the masked interrupt word to the computer on a read strobe, then sequences re-arm after end-of-service.

---
 rtl/int_request_arb_if.sv | 39 +++
 rtl/int_request_arb.sv | 134 +++++++++++++
 tb/tb_int_request_arb.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/int_request_arb_if.sv
// Interrupt request bus between the discrete sources/LVDC side and the arbiter.
// master drives sources, inhibits and strobes; slave is the arbiter.
interface int_request_arb_if #(
    parameter int N_INT = 13
);
    logic [N_INT-1:0] int_src;
    logic [N_INT-1:0] icr_n;
    logic             rd_stb;
    logic             int_done;
    logic             intreq;
    logic [N_INT-1:0] int_word;
    logic [3:0]       int_id;
    logic [N_INT-1:0] pend;
    logic             int_tmo;

    modport master (
        output int_src,
        output icr_n,
        output rd_stb,
        output int_done,
        input  intreq,
        input  int_word,
        input  int_id,
        input  pend,
        input  int_tmo
    );

    modport slave (
        input  int_src,
        input  icr_n,
        input  rd_stb,
        input  int_done,
        output intreq,
        output int_word,
        output int_id,
        output pend,
        output int_tmo
    );
endinterface

// File: rtl/int_request_arb.sv
// Interrupt request arbiter: edge-latches discrete sources, masks with ICR, requests LVDC.
// Optional REQ-state timeout flag enabled by defining INT_TIMEOUT_EN.
module int_request_arb #(
    parameter int N_INT       = 13,
    parameter int SYNC_STAGES = 2,
    parameter int HOLDOFF_CYC = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input logic              sim_clk,
    input logic              sim_rst,
    int_request_arb_if.slave bus
);
    localparam int HW = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE,
        HOLDOFF
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0][N_INT-1:0] sync_q;
    logic [N_INT-1:0] last_q;
    logic [N_INT-1:0] rise;
    logic [N_INT-1:0] pend_q;
    logic [N_INT-1:0] masked;
    logic [N_INT-1:0] clr;
    logic [N_INT-1:0] word_q, word_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic             intreq_q;
    logic [3:0]       id;

    assign rise   = sync_q[SYNC_STAGES-1] & ~last_q;
    assign masked = pend_q & bus.icr_n;

    always_ff @(posedge sim_clk or posedge sim_rst) begin
        if (sim_rst) begin
            sync_q <= '0;
            last_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.int_src};
            last_q <= sync_q[SYNC_STAGES-1];
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        word_d  = word_q;
        clr     = '0;
        unique case (state_q)
            IDLE: begin
                if (|masked) state_d = REQ;
            end
            REQ: begin
                // A fully inhibited word withdraws the request
                if (masked == '0) begin
                    state_d = IDLE;
                end else if (bus.rd_stb) begin
                    state_d = SERVICE;
                    word_d  = masked;
                    clr     = masked;
                end
            end
            SERVICE: begin
                if (bus.int_done) begin
                    state_d = HOLDOFF;
                    hold_d  = HW'(HOLDOFF_CYC - 1);
                end
            end
            HOLDOFF: begin
                if (hold_q == '0) state_d = IDLE;
                else hold_d = hold_q - HW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sim_clk or posedge sim_rst) begin
        if (sim_rst) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            word_q   <= '0;
            pend_q   <= '0;
            intreq_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            word_q   <= word_d;
            // Set after clear so a new edge on the read cycle survives
            pend_q   <= (pend_q & ~clr) | rise;
            intreq_q <= (state_d == REQ);
        end
    end

    always_comb begin
        id = '0;
        for (int k = N_INT - 1; k >= 0; k--) begin
            if (masked[k]) id = 4'(k + 1);
        end
    end

`ifdef INT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] tmo_cnt_q;
    logic          tmo_q;

    always_ff @(posedge sim_clk or posedge sim_rst) begin
        if (sim_rst) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else if (state_q == REQ) begin
            if (tmo_cnt_q != TW'(TIMEOUT_CYC))
                tmo_cnt_q <= tmo_cnt_q + TW'(1);
            if (tmo_cnt_q == TW'(TIMEOUT_CYC - 1))
                tmo_q <= 1'b1;
        end else begin
            tmo_cnt_q <= '0;
        end
    end

    assign bus.int_tmo = tmo_q;
`else
    assign bus.int_tmo = 1'b0;
`endif

    assign bus.intreq   = intreq_q;
    assign bus.int_word = word_q;
    assign bus.int_id   = id;
    assign bus.pend     = pend_q;
endmodule

// File: tb/tb_int_request_arb.sv
// Bench for int_request_arb: directed scenarios plus random traffic
// against an event-level reference model.
module tb_int_request_arb;
    localparam int N = 13;
    localparam int S = 2;
    localparam int H = 4;
    localparam int T = 8;

    logic sim_clk = 1'b0;
    logic sim_rst;

    always #5 sim_clk = ~sim_clk;

    int_request_arb_if #(.N_INT(N)) bus ();

    int_request_arb #(
        .N_INT      (N),
        .SYNC_STAGES(S),
        .HOLDOFF_CYC(H),
        .TIMEOUT_CYC(T)
    ) dut (
        .sim_clk(sim_clk),
        .sim_rst(sim_rst),
        .bus    (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: an event is a 0->1 of the input as seen S+1
    // clocks ago; request/service/holdoff tracked as flags plus the
    // earliest cycle at which a new request may be raised.
    logic [N-1:0] hist[0:S];
    logic [N-1:0] m_pend, m_word, m_msk, m_set, m_clr;
    bit           m_req, m_svc, m_tmo;
    int           cyc, ready_at, req_run;

    always @(posedge sim_clk or posedge sim_rst) begin
        if (sim_rst) begin
            for (int j = 0; j <= S; j++) hist[j] = '0;
            m_pend   = '0;
            m_word   = '0;
            m_req    = 0;
            m_svc    = 0;
            m_tmo    = 0;
            cyc      = 0;
            ready_at = 0;
            req_run  = 0;
        end else begin
            m_msk = m_pend & bus.icr_n;
            m_set = hist[S-1] & ~hist[S];
            m_clr = '0;
            if (m_req) begin
                req_run++;
`ifdef INT_TIMEOUT_EN
                if (req_run >= T) m_tmo = 1;
`endif
            end else begin
                req_run = 0;
            end
            if (m_req) begin
                if (m_msk == '0) begin
                    m_req = 0;
                end else if (bus.rd_stb) begin
                    m_word = m_msk;
                    m_clr  = m_msk;
                    m_req  = 0;
                    m_svc  = 1;
                end
            end else if (m_svc) begin
                if (bus.int_done) begin
                    m_svc    = 0;
                    ready_at = cyc + H + 1;
                end
            end else if (cyc >= ready_at && m_msk != '0) begin
                m_req = 1;
            end
            m_pend = (m_pend & ~m_clr) | m_set;
            for (int j = S; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = bus.int_src;
            cyc++;
        end
    end

    function automatic logic [3:0] exp_id(logic [N-1:0] m);
        logic [3:0] r = '0;
        for (int k = N - 1; k >= 0; k--)
            if (m[k]) r = 4'(k + 1);
        return r;
    endfunction

    task automatic compare_all();
        check("intreq", 32'(bus.intreq), 32'(m_req));
        check("pend", 32'(bus.pend), 32'(m_pend));
        check("word", 32'(bus.int_word), 32'(m_word));
        check("id", 32'(bus.int_id),
              32'(exp_id(m_pend & bus.icr_n)));
        check("tmo", 32'(bus.int_tmo), 32'(m_tmo));
    endtask

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge sim_clk);
            @(negedge sim_clk);
            compare_all();
        end
    endtask

    task automatic read_and_done();
        bus.rd_stb = 1'b1;
        step();
        bus.rd_stb = 1'b0;
        bus.int_done = 1'b1;
        step();
        bus.int_done = 1'b0;
    endtask

    int      k;
    bit      tmo_exp;
    logic [N-1:0] flip;

    initial begin
`ifdef INT_TIMEOUT_EN
        tmo_exp = 1;
`else
        tmo_exp = 0;
`endif
        sim_rst      = 1'b1;
        bus.int_src  = '0;
        bus.icr_n    = '1;
        bus.rd_stb   = 1'b0;
        bus.int_done = 1'b0;
        repeat (2) @(negedge sim_clk);
        check("rst_intreq", 32'(bus.intreq), 0);
        check("rst_pend", 32'(bus.pend), 0);
        sim_rst = 1'b0;
        step(2);

        // Single event on channel 5
        bus.int_src[4] = 1'b1;
        step(2);
        check("pend4_early", 32'(bus.pend[4]), 0);
        step();
        check("pend4_set", 32'(bus.pend[4]), 1);
        step();
        check("single_req", 32'(bus.intreq), 1);
        check("single_id", 32'(bus.int_id), 5);
        bus.rd_stb = 1'b1;
        step();
        bus.rd_stb = 1'b0;
        check("single_word", 32'(bus.int_word), 32'h10);
        check("single_pend", 32'(bus.pend), 0);
        check("single_drop", 32'(bus.intreq), 0);
        bus.int_done = 1'b1;
        step();
        bus.int_done = 1'b0;
        bus.int_src  = '0;
        step(6);

        // Inhibited channel stays latched, requests on release
        bus.icr_n = ~13'h0001;
        bus.int_src[0] = 1'b1;
        step();
        bus.int_src[0] = 1'b0;
        step(4);
        check("inh_pend", 32'(bus.pend[0]), 1);
        check("inh_req", 32'(bus.intreq), 0);
        check("inh_id", 32'(bus.int_id), 0);
        bus.icr_n = '1;
        step();
        check("uninh_req", 32'(bus.intreq), 1);
        check("uninh_id", 32'(bus.int_id), 1);
        read_and_done();
        step(6);

        // Priority and same-cycle set/clear collision
        bus.int_src = 13'h0204;
        step(4);
        check("prio_req", 32'(bus.intreq), 1);
        check("prio_id", 32'(bus.int_id), 3);
        bus.int_src[2] = 1'b0;
        step(3);
        bus.int_src[2] = 1'b1;
        step(2);
        bus.rd_stb = 1'b1;
        step();
        bus.rd_stb = 1'b0;
        check("coll_word", 32'(bus.int_word), 32'h204);
        check("coll_pend", 32'(bus.pend), 32'h004);

        // Holdoff: re-request exactly H+1 cycles after INT_DONE
        bus.int_done = 1'b1;
        step();
        bus.int_done = 1'b0;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.intreq) break;
            step();
            k++;
        end
        check("holdoff_cyc", 32'(k), 32'(H + 1));
        read_and_done();
        bus.int_src = '0;
        step(6);

        // Held request: timeout flag when enabled, sticky past the read
        bus.int_src[7] = 1'b1;
        step(4);
        check("tmo_req", 32'(bus.intreq), 1);
        step(T);
        check("tmo_flag", 32'(bus.int_tmo), 32'(tmo_exp));
        check("tmo_intreq", 32'(bus.intreq), 1);
        read_and_done();
        check("tmo_sticky", 32'(bus.int_tmo), 32'(tmo_exp));
        bus.int_src = '0;
        step(6);

        // Asynchronous reset mid-request
        bus.int_src = 13'h0005;
        step(4);
        check("prerst_req", 32'(bus.intreq), 1);
        check("prerst_pend", 32'(bus.pend), 32'h5);
        #2 sim_rst = 1'b1;
        #1;
        check("arst_intreq", 32'(bus.intreq), 0);
        check("arst_pend", 32'(bus.pend), 0);
        check("arst_word", 32'(bus.int_word), 0);
        check("arst_id", 32'(bus.int_id), 0);
        check("arst_tmo", 32'(bus.int_tmo), 0);
        bus.int_src = '0;
        step(2);
        sim_rst = 1'b0;
        step(6);
        check("postrst_req", 32'(bus.intreq), 0);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            flip = '0;
            for (int b = 0; b < N; b++)
                flip[b] = ($urandom_range(7) == 0);
            bus.int_src ^= flip;
            if ($urandom_range(15) == 0)
                bus.icr_n = N'($urandom | $urandom);
            bus.rd_stb   = ($urandom_range(3) == 0);
            bus.int_done = ($urandom_range(3) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end
endmodule
